// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types for register-file access paths.
package cpu_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 64;
  localparam int XZR_IDX   = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (en && !found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        winner   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the single register-file read port among NUM_REQ requesters through a
// two-stage accept/read pipeline with a tagged response register.
module regfile_read_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  reg_idx_t [NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]       req_ready,
  output reg_idx_t                 rf_sel,
  input  data_t                    rf_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output data_t                    rsp_data,
  output logic                     busy
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] ptr_next;
  logic            grant_any;
  logic            grant_en;
  logic            s1_valid;
  logic            s1_zero;
  logic            s1_adv;
  logic [ID_W-1:0] s1_id;

  // S1 moves into the response register when that register is empty or draining.
  assign s1_adv   = s1_valid && (!rsp_valid || rsp_ready);
  assign grant_en = !s1_valid || s1_adv;
  assign ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  assign busy     = s1_valid || rsp_valid;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (grant_en),
    .grant  (req_ready),
    .winner (win_id),
    .found  (grant_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_id     <= '0;
      rf_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (grant_any) begin
        s1_valid <= 1'b1;
        s1_id    <= win_id;
        rf_sel   <= req_addr[win_id];
        s1_zero  <= (req_addr[win_id] == reg_idx_t'(ZERO_REG));
        rr_ptr   <= ptr_next;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        rsp_valid <= 1'b1;
        rsp_id    <= s1_id;
        rsp_data  <= s1_zero ? '0 : rf_rdata;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a response scoreboard and a
// round-robin pointer model.
module tb_regfile_read_arbiter;
  import cpu_pkg::*;

  localparam int NR = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0][4:0]  req_addr = '0;
  logic [NR-1:0]       req_ready;
  logic [4:0]          rf_sel;
  logic [63:0]         rf_rdata;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [1:0]          rsp_id;
  logic [63:0]         rsp_data;
  logic                busy;

  logic [63:0] regfile [32];
  assign rf_rdata = regfile[rf_sel];

  regfile_read_arbiter #(.NUM_REQ(NR), .ID_W(2), .ZERO_REG(31)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rf_sel(rf_sel), .rf_rdata(rf_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  int grant_cnt [NR];
  logic        hold = 1'b0;
  logic [1:0]  hold_id;
  logic [63:0] hold_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pointer model, grant legality, scoreboard push/pop and hold stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      mptr = 0;
      hold = 1'b0;
    end else begin
      check("rr_ptr", 64'(dut.rr_ptr), 64'(mptr));
      check("ready_only_valid", 64'(req_ready & ~req_valid), 64'h0);
      if (hold) begin
        check("hold_valid", 64'(rsp_valid), 64'h1);
        check("hold_id", 64'(rsp_id), 64'(hold_id));
        check("hold_data", rsp_data, hold_data);
      end
      if (req_ready != '0) begin
        int  ek;
        bit  fnd;
        rsp_t e;
        fnd = 1'b0;
        ek  = 0;
        for (int i = 0; i < NR; i++) begin
          int k;
          k = (mptr + i) % NR;
          if (!fnd && req_valid[k]) begin
            fnd = 1'b1;
            ek  = k;
          end
        end
        if (fnd) begin
          check("grant_rr", 64'(req_ready), 64'(1 << ek));
          e.id   = 2'(ek);
          e.data = (req_addr[ek] == 5'd31) ? 64'h0 : regfile[req_addr[ek]];
          sb.push_back(e);
          grant_cnt[ek]++;
          mptr = (ek + 1) % NR;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'h1, 64'h0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_data", rsp_data, e.data);
        end
      end
      hold      = rsp_valid && !rsp_ready;
      hold_id   = rsp_id;
      hold_data = rsp_data;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n   = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_req_ready"}, 64'(req_ready), 64'h0);
    check({tag, "_rf_sel"}, 64'(rf_sel), 64'h0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'h0);
    check({tag, "_rsp_data"}, rsp_data, 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  task automatic issue(input int k, input logic [4:0] a);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_addr[k]  = a;
    req_valid[k] = 1'b1;
    @(negedge clk);
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 64'(req_ready[k]), 64'h1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(posedge clk); #2;
    while ((busy || sb.size() != 0) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_drained"}, 64'(!busy && sb.size() == 0), 64'h1);
  endtask

  initial begin
    logic [4:0] sel_snap;
    int c0, c2;

    for (int i = 0; i < 32; i++) regfile[i] = {32'h1234_0000, 24'h0, 8'(i)} ^ 64'hA5A5_0000_0000_0000;
    regfile[5] = 64'h0000_0000_DEAD_BEEF;
    for (int i = 0; i < NR; i++) grant_cnt[i] = 0;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_reset_state("reset");

    // 1: single read, latency and data
    @(posedge clk); #1;
    req_addr[0]  = 5'd5;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t1_ready_cycle1", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_rsp_not_yet", 64'(rsp_valid), 64'h0);
    check("t1_busy", 64'(busy), 64'h1);
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_id", 64'(rsp_id), 64'h0);
    check("t1_rsp_data", rsp_data, 64'h0000_0000_DEAD_BEEF);
    drain("t1");

    // 2: all requesters streaming, full throughput in round-robin order
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) req_addr[i] = 5'(i + 1);
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_grant_order", 64'(req_ready), 64'(1 << (i % NR)));
      if (i >= 2) check("t2_throughput", 64'(rsp_valid), 64'h1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain("t2");

    // 3: zero register reads as zero
    regfile[31] = '1;
    issue(1, 5'd31);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 5) begin
        @(negedge clk);
        n++;
      end
      check("t3_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t3_rsp_id", 64'(rsp_id), 64'h1);
      check("t3_rsp_data", rsp_data, 64'h0);
    end
    drain("t3");

    // 4: response back-pressure with a continuous request stream
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) req_addr[i] = 5'(10 + i);
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) sel_snap = rf_sel;
      if (i >= 3) begin
        check("t4_stalled_ready", 64'(req_ready), 64'h0);
        check("t4_rf_sel_stable", 64'(rf_sel), 64'(sel_snap));
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    drain("t4");

    // 5: reset while S1 and the response register are both full
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_full_busy", 64'(busy && rsp_valid), 64'h1);
    reset_n   = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    check_reset_state("t5");
    repeat (3) begin
      @(negedge clk);
      check("t5_no_stale_rsp", 64'(rsp_valid), 64'h0);
    end

    // 6: lone requester, then a second joins mid-stream
    @(posedge clk); #1;
    req_addr[2]  = 5'd7;
    req_addr[0]  = 5'd9;
    req_valid[2] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("t6_ptr_after_req2", 64'(dut.rr_ptr), 64'h3);
    c0 = grant_cnt[0];
    c2 = grant_cnt[2];
    req_valid[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("t6_req2_not_starved", 64'(grant_cnt[2] - c2 >= 2), 64'h1);
    check("t6_req0_served", 64'(grant_cnt[0] - c0 >= 2), 64'h1);
    req_valid = '0;
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
